// File: rtl/matrix_issue_sched_pkg.sv
// Shared types for the matrix issue scheduler: register index, address word,
// matrix opcode and the decoded instruction held in the issue entry.
package matrix_issue_sched_pkg;

    localparam int NUM_MREGS   = 16;
    localparam int MREG_W      = $clog2(NUM_MREGS);
    localparam int ADDR_W      = 32;
    localparam int STALL_CNT_W = 16;

    typedef logic [MREG_W-1:0] mreg_t;
    typedef logic [ADDR_W-1:0] word_t;

    typedef enum logic [1:0] {
        MOP_LD   = 2'd0,
        MOP_ST   = 2'd1,
        MOP_GEMM = 2'd2,
        MOP_RSVD = 2'd3
    } mop_t;

    typedef struct packed {
        mop_t  op;
        mreg_t rd;
        mreg_t rs1;
        mreg_t rs2;
        mreg_t rs3;
        word_t addr;
    } matrix_instr_t;

endpackage

// File: rtl/matrix_issue_sched_if.sv
// Handshake bundle between decode, the scheduler and the two matrix units.
// master = scheduler view, slave = surrounding decode/MLSU/GEMM view.
interface matrix_issue_sched_if;
    import matrix_issue_sched_pkg::*;

    // decode -> scheduler
    logic       m_valid;
    logic       m_ready;
    logic [1:0] m_op;
    mreg_t      m_rd;
    mreg_t      m_rs1;
    mreg_t      m_rs2;
    mreg_t      m_rs3;
    word_t      m_addr;

    // scheduler <-> MLSU
    logic       ls_valid;
    logic       ls_ready;
    logic       ls_store;
    mreg_t      ls_mreg;
    word_t      ls_addr;
    logic       ls_done;

    // scheduler <-> GEMM unit
    logic       g_valid;
    logic       g_ready;
    mreg_t      g_rs1;
    mreg_t      g_rs2;
    mreg_t      g_rs3;
    mreg_t      g_rd;
    logic       g_done;

    modport master (
        input  m_valid, m_op, m_rd, m_rs1, m_rs2, m_rs3, m_addr,
        output m_ready,
        output ls_valid, ls_store, ls_mreg, ls_addr,
        input  ls_ready, ls_done,
        output g_valid, g_rs1, g_rs2, g_rs3, g_rd,
        input  g_ready, g_done
    );

    modport slave (
        output m_valid, m_op, m_rd, m_rs1, m_rs2, m_rs3, m_addr,
        input  m_ready,
        input  ls_valid, ls_store, ls_mreg, ls_addr,
        output ls_ready, ls_done,
        input  g_valid, g_rs1, g_rs2, g_rs3, g_rd,
        output g_ready, g_done
    );

endinterface

// File: rtl/matrix_issue_sched_mreg_scoreboard.sv
// Combinational matrix-register scoreboard: turns the in-flight MLSU/GEMM
// records into write-busy / read-busy vectors and flags a hazard for the
// instruction currently held in the issue entry.
module mreg_scoreboard
    import matrix_issue_sched_pkg::*;
(
    input  logic                 ls_inflight,
    input  logic                 ls_store,
    input  mreg_t                ls_mreg,
    input  logic                 g_inflight,
    input  mreg_t                g_rd,
    input  mreg_t                g_rs1,
    input  mreg_t                g_rs2,
    input  mreg_t                g_rs3,
    input  mop_t                 ent_op,
    input  mreg_t                ent_rd,
    input  mreg_t                ent_rs1,
    input  mreg_t                ent_rs2,
    input  mreg_t                ent_rs3,
    output logic [NUM_MREGS-1:0] wbusy,
    output logic [NUM_MREGS-1:0] rbusy,
    output logic                 hazard
);

    // Busy vectors from in-flight records, then RAW/WAR/WAW check for the entry
    always_comb begin
        wbusy = '0;
        rbusy = '0;
        if (ls_inflight) begin
            if (ls_store) rbusy[ls_mreg] = 1'b1;
            else          wbusy[ls_mreg] = 1'b1;
        end
        if (g_inflight) begin
            wbusy[g_rd]  = 1'b1;
            rbusy[g_rs1] = 1'b1;
            rbusy[g_rs2] = 1'b1;
            rbusy[g_rs3] = 1'b1;
        end

        hazard = 1'b0;
        case (ent_op)
            MOP_LD:   hazard = wbusy[ent_rd] || rbusy[ent_rd];
            MOP_ST:   hazard = wbusy[ent_rs1];
            MOP_GEMM: hazard = wbusy[ent_rs1] || wbusy[ent_rs2] || wbusy[ent_rs3] ||
                               wbusy[ent_rd]  || rbusy[ent_rd];
            default:  hazard = 1'b0;
        endcase
    end

endmodule

// File: rtl/matrix_issue_sched.sv
// Single-entry matrix issue scheduler: holds one decoded ld.m/st.m/gemm,
// waits out register hazards, issues to the MLSU or GEMM unit and tracks
// one in-flight operation per unit until its done pulse.
module matrix_issue_sched
    import matrix_issue_sched_pkg::*;
(
    input  logic                   CLK,
    input  logic                   nRST,
    matrix_issue_sched_if.master   bus,
    input  logic                   drain_req,
    output logic                   drained,
    output logic                   err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    matrix_instr_t          ent_q, ent_d, in_instr;
    logic                   ent_valid_q, ent_valid_d;
    logic                   ls_inflight_q, ls_inflight_d;
    logic                   g_inflight_q, g_inflight_d;
    logic                   ls_store_q, ls_store_d;
    mreg_t                  ls_mreg_q, ls_mreg_d;
    mreg_t                  g_rd_q, g_rd_d, g_rs1_q, g_rs1_d, g_rs2_q, g_rs2_d, g_rs3_q, g_rs3_d;
    logic                   err_q, err_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [NUM_MREGS-1:0]   wbusy, rbusy;
    logic                   hazard;
    logic                   ent_is_ls, ent_is_st;
    logic                   ls_valid, g_valid, ls_fire, g_fire, issue_fire;
    logic                   m_ready, accept;
    mreg_t                  ent_ls_mreg;

    mreg_scoreboard u_sb (
        .ls_inflight (ls_inflight_q),
        .ls_store    (ls_store_q),
        .ls_mreg     (ls_mreg_q),
        .g_inflight  (g_inflight_q),
        .g_rd        (g_rd_q),
        .g_rs1       (g_rs1_q),
        .g_rs2       (g_rs2_q),
        .g_rs3       (g_rs3_q),
        .ent_op      (ent_q.op),
        .ent_rd      (ent_q.rd),
        .ent_rs1     (ent_q.rs1),
        .ent_rs2     (ent_q.rs2),
        .ent_rs3     (ent_q.rs3),
        .wbusy       (wbusy),
        .rbusy       (rbusy),
        .hazard      (hazard)
    );

    assign in_instr = '{op:   mop_t'(bus.m_op),
                        rd:   bus.m_rd,
                        rs1:  bus.m_rs1,
                        rs2:  bus.m_rs2,
                        rs3:  bus.m_rs3,
                        addr: bus.m_addr};

    // A store sends its data source to the MLSU, a load its destination
    assign ent_is_st   = (ent_q.op == MOP_ST);
    assign ent_is_ls   = (ent_q.op == MOP_LD) || ent_is_st;
    assign ent_ls_mreg = ent_is_st ? ent_q.rs1 : ent_q.rd;

    assign ls_valid   = ent_valid_q && ent_is_ls && !hazard && !ls_inflight_q;
    assign g_valid    = ent_valid_q && (ent_q.op == MOP_GEMM) && !hazard && !g_inflight_q;
    assign ls_fire    = ls_valid && bus.ls_ready;
    assign g_fire     = g_valid && bus.g_ready;
    assign issue_fire = ls_fire || g_fire;
    assign m_ready    = !drain_req && (!ent_valid_q || issue_fire);
    assign accept     = bus.m_valid && m_ready;

    assign bus.m_ready  = m_ready;
    assign bus.ls_valid = ls_valid;
    assign bus.ls_store = ent_is_st;
    assign bus.ls_mreg  = ent_ls_mreg;
    assign bus.ls_addr  = ent_q.addr;
    assign bus.g_valid  = g_valid;
    assign bus.g_rd     = ent_q.rd;
    assign bus.g_rs1    = ent_q.rs1;
    assign bus.g_rs2    = ent_q.rs2;
    assign bus.g_rs3    = ent_q.rs3;

    // Every in-flight op marks at least one busy bit, so an all-clear
    // scoreboard means both units are idle
    assign drained   = !ent_valid_q && !(|wbusy) && !(|rbusy);
    assign err       = err_q;
    assign stall_cnt = stall_cnt_q;

    // Next-state for entry, in-flight flags/records, error and stall counter
    always_comb begin
        ent_valid_d = ent_valid_q;
        if (issue_fire) ent_valid_d = 1'b0;
        if (accept)     ent_valid_d = (in_instr.op != MOP_RSVD);
        ent_d = accept ? in_instr : ent_q;

        // A unit never fires while busy, so fire and done cannot collide on one flag
        ls_inflight_d = ls_inflight_q;
        if (bus.ls_done) ls_inflight_d = 1'b0;
        if (ls_fire)     ls_inflight_d = 1'b1;
        g_inflight_d = g_inflight_q;
        if (bus.g_done)  g_inflight_d = 1'b0;
        if (g_fire)      g_inflight_d = 1'b1;

        ls_store_d = ls_fire ? ent_is_st   : ls_store_q;
        ls_mreg_d  = ls_fire ? ent_ls_mreg : ls_mreg_q;
        g_rd_d     = g_fire  ? ent_q.rd    : g_rd_q;
        g_rs1_d    = g_fire  ? ent_q.rs1   : g_rs1_q;
        g_rs2_d    = g_fire  ? ent_q.rs2   : g_rs2_q;
        g_rs3_d    = g_fire  ? ent_q.rs3   : g_rs3_q;

        err_d = err_q
              || (accept && (in_instr.op == MOP_RSVD))
              || (bus.ls_done && !ls_inflight_q)
              || (bus.g_done  && !g_inflight_q);

        stall_cnt_d = stall_cnt_q;
        if (ent_valid_q && hazard && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Control state; reset discards the entry and any in-flight tracking
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ent_valid_q   <= 1'b0;
            ls_inflight_q <= 1'b0;
            g_inflight_q  <= 1'b0;
            err_q         <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            ent_valid_q   <= ent_valid_d;
            ls_inflight_q <= ls_inflight_d;
            g_inflight_q  <= g_inflight_d;
            err_q         <= err_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    // Payload state; only meaningful while the matching valid/in-flight flag is set
    always_ff @(posedge CLK) begin
        ent_q      <= ent_d;
        ls_store_q <= ls_store_d;
        ls_mreg_q  <= ls_mreg_d;
        g_rd_q     <= g_rd_d;
        g_rs1_q    <= g_rs1_d;
        g_rs2_q    <= g_rs2_d;
        g_rs3_q    <= g_rs3_d;
    end

endmodule

// File: tb/tb_matrix_issue_sched.sv
// Bench for matrix_issue_sched: directed scenarios followed by random traffic,
// checked against an instruction-level reference model and issue scoreboards.
module tb_matrix_issue_sched;
    import matrix_issue_sched_pkg::*;

    logic                   CLK = 1'b0;
    logic                   nRST;
    logic                   drain_req;
    logic                   drained;
    logic                   err;
    logic [STALL_CNT_W-1:0] stall_cnt;

    matrix_issue_sched_if bus();

    matrix_issue_sched dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (bus),
        .drain_req (drain_req),
        .drained   (drained),
        .err       (err),
        .stall_cnt (stall_cnt)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (instruction level) ----------------
    bit            m_pv;              // an accepted instruction is waiting to issue
    matrix_instr_t m_p;
    bit            m_lsb, m_ls_st;    // MLSU busy, and whether it is a store
    mreg_t         m_ls_reg;
    bit            m_gb;              // GEMM busy
    matrix_instr_t m_g;
    bit            m_err;
    int            m_stall;
    matrix_instr_t exp_ls[$];
    matrix_instr_t exp_g[$];

    function automatic bit writing(mreg_t r);
        return (m_lsb && !m_ls_st && m_ls_reg == r) || (m_gb && m_g.rd == r);
    endfunction

    function automatic bit reading(mreg_t r);
        return (m_lsb && m_ls_st && m_ls_reg == r) ||
               (m_gb && (m_g.rs1 == r || m_g.rs2 == r || m_g.rs3 == r));
    endfunction

    function automatic bit conflict(matrix_instr_t i);
        case (i.op)
            MOP_LD:   return writing(i.rd) || reading(i.rd);
            MOP_ST:   return writing(i.rs1);
            MOP_GEMM: return writing(i.rs1) || writing(i.rs2) || writing(i.rs3) ||
                             writing(i.rd) || reading(i.rd);
            default:  return 1'b0;
        endcase
    endfunction

    always @(negedge CLK) begin
        bit haz, elv, egv, lf, gf, emr;
        matrix_instr_t ni;
        if (!nRST) begin
            m_pv = 0; m_lsb = 0; m_gb = 0; m_err = 0; m_stall = 0;
            exp_ls.delete();
            exp_g.delete();
            chk("rst_ls_valid", bus.ls_valid, 0);
            chk("rst_g_valid",  bus.g_valid, 0);
            chk("rst_m_ready",  bus.m_ready, !drain_req);
            chk("rst_drained",  drained, 1);
            chk("rst_err",      err, 0);
            chk("rst_stall",    stall_cnt, 0);
        end else begin
            haz = m_pv && conflict(m_p);
            elv = m_pv && (m_p.op == MOP_LD || m_p.op == MOP_ST) && !haz && !m_lsb;
            egv = m_pv && (m_p.op == MOP_GEMM) && !haz && !m_gb;
            lf  = elv && bus.ls_ready;
            gf  = egv && bus.g_ready;
            emr = !drain_req && (!m_pv || lf || gf);
            chk("m_ready",   bus.m_ready, emr);
            chk("ls_valid",  bus.ls_valid, elv);
            chk("g_valid",   bus.g_valid, egv);
            chk("drained",   drained, !m_pv && !m_lsb && !m_gb);
            chk("err",       err, m_err);
            chk("stall_cnt", stall_cnt, m_stall);

            if (m_pv && haz && m_stall < 65535) m_stall++;
            if (bus.ls_done) begin
                if (m_lsb) m_lsb = 0; else m_err = 1;
            end
            if (bus.g_done) begin
                if (m_gb) m_gb = 0; else m_err = 1;
            end
            if (lf) begin
                m_lsb    = 1;
                m_ls_st  = (m_p.op == MOP_ST);
                m_ls_reg = m_ls_st ? m_p.rs1 : m_p.rd;
            end
            if (gf) begin
                m_gb = 1;
                m_g  = m_p;
            end
            if (lf || gf) m_pv = 0;
            if (bus.m_valid && emr) begin
                ni = '{op: mop_t'(bus.m_op), rd: bus.m_rd, rs1: bus.m_rs1,
                       rs2: bus.m_rs2, rs3: bus.m_rs3, addr: bus.m_addr};
                if (ni.op == MOP_RSVD) m_err = 1;
                else begin
                    m_pv = 1;
                    m_p  = ni;
                    if (ni.op == MOP_GEMM) exp_g.push_back(ni);
                    else                   exp_ls.push_back(ni);
                end
            end
        end
    end

    // ---------------- issue monitor: payload of every handshake ----------------
    always @(negedge CLK) begin
        matrix_instr_t e;
        if (nRST) begin
            if (bus.ls_valid && bus.ls_ready) begin
                chk("ls_issue_expected", exp_ls.size() != 0, 1);
                if (exp_ls.size() != 0) begin
                    e = exp_ls.pop_front();
                    chk("ls_store", bus.ls_store, e.op == MOP_ST);
                    chk("ls_mreg",  bus.ls_mreg, (e.op == MOP_ST) ? e.rs1 : e.rd);
                    chk("ls_addr",  bus.ls_addr, e.addr);
                end
            end
            if (bus.g_valid && bus.g_ready) begin
                chk("g_issue_expected", exp_g.size() != 0, 1);
                if (exp_g.size() != 0) begin
                    e = exp_g.pop_front();
                    chk("g_ops", {bus.g_rd, bus.g_rs1, bus.g_rs2, bus.g_rs3},
                                 {e.rd, e.rs1, e.rs2, e.rs3});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        cyc();
        cyc();
        nRST = 1'b1;
    endtask

    task automatic put(input int op, input int rd, input int a, input int b, input int c,
                       input logic [31:0] ad);
        bus.m_valid = 1'b1;
        bus.m_op    = op[1:0];
        bus.m_rd    = rd[MREG_W-1:0];
        bus.m_rs1   = a[MREG_W-1:0];
        bus.m_rs2   = b[MREG_W-1:0];
        bus.m_rs3   = c[MREG_W-1:0];
        bus.m_addr  = ad;
        cyc();
        bus.m_valid = 1'b0;
        #1;
    endtask

    initial begin
        nRST = 1'b0; drain_req = 1'b0;
        bus.m_valid = 0; bus.m_op = 0; bus.m_rd = 0; bus.m_rs1 = 0; bus.m_rs2 = 0;
        bus.m_rs3 = 0; bus.m_addr = 0;
        bus.ls_ready = 1; bus.ls_done = 0; bus.g_ready = 1; bus.g_done = 0;
        do_reset();

        // LD m2 @0x100: presented the cycle after acceptance
        put(0, 2, 0, 0, 0, 32'h100);
        chk("ld_first_valid", bus.ls_valid, 1);
        chk("ld_first_store", bus.ls_store, 0);
        chk("ld_first_mreg",  bus.ls_mreg, 2);
        chk("ld_first_addr",  bus.ls_addr, 32'h100);
        chk("ld_first_ready", bus.m_ready, 1);
        cyc();
        bus.ls_done = 1; cyc(); bus.ls_done = 0;

        // RAW: GEMM reads m1 while LD m1 is in flight
        put(0, 1, 0, 0, 0, 32'h200);
        put(2, 4, 1, 2, 3, 0);
        repeat (3) begin
            chk("raw_g_blocked", bus.g_valid, 0);
            cyc();
        end
        bus.ls_done = 1;
        #1 chk("raw_g_blocked_done_cycle", bus.g_valid, 0);
        cyc(); bus.ls_done = 0;
        #1 chk("raw_g_after_done", bus.g_valid, 1);
        cyc();
        bus.g_done = 1; cyc(); bus.g_done = 0;

        // WAR: LD m5 waits for the GEMM reading m5; drain observed
        put(2, 8, 5, 6, 7, 0);
        put(0, 5, 0, 0, 0, 32'h300);
        repeat (3) begin
            chk("war_ls_blocked", bus.ls_valid, 0);
            cyc();
        end
        drain_req = 1; cyc();
        chk("war_not_drained", drained, 0);
        bus.g_done = 1; cyc(); bus.g_done = 0;
        #1 chk("war_ls_after_done", bus.ls_valid, 1);
        cyc();
        chk("war_ld_inflight", drained, 0);
        bus.ls_done = 1; cyc(); bus.ls_done = 0;
        #1 chk("war_drained", drained, 1);
        drain_req = 0;

        // Overlap: ST m6 issues under an in-flight GEMM; simultaneous dones
        put(2, 7, 1, 2, 3, 0);
        put(1, 0, 6, 0, 0, 32'h400);
        chk("ovl_st_valid", bus.ls_valid, 1);
        cyc();
        bus.g_done = 1; bus.ls_done = 1; cyc(); bus.g_done = 0; bus.ls_done = 0;
        #1 chk("ovl_drained", drained, 1);

        // Spurious done sets a sticky error
        bus.g_done = 1; cyc(); bus.g_done = 0;
        repeat (3) begin
            chk("err_sticky", err, 1);
            cyc();
        end

        // Reserved op: accepted, dropped, error
        do_reset();
        chk("err_cleared", err, 0);
        put(3, 1, 2, 3, 4, 32'h500);
        chk("rsvd_err", err, 1);
        chk("rsvd_no_issue", bus.ls_valid | bus.g_valid, 0);
        chk("rsvd_drained", drained, 1);
        cyc();

        // Reset while LD is in flight, then a stale done
        do_reset();
        put(0, 3, 0, 0, 0, 32'h600);
        cyc();
        #2 nRST = 1'b0;
        #1;
        chk("mid_rst_ls_valid", bus.ls_valid, 0);
        chk("mid_rst_m_ready",  bus.m_ready, 1);
        chk("mid_rst_drained",  drained, 1);
        chk("mid_rst_err",      err, 0);
        cyc(); nRST = 1'b1;
        cyc();
        bus.ls_done = 1; cyc(); bus.ls_done = 0;
        #1 chk("stale_done_err", err, 1);

        // Random traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bus.m_valid  = ($urandom % 3) != 0;
            bus.m_op     = 2'($urandom % 3);
            bus.m_rd     = MREG_W'($urandom % 8);
            bus.m_rs1    = MREG_W'($urandom % 8);
            bus.m_rs2    = MREG_W'($urandom % 8);
            bus.m_rs3    = MREG_W'($urandom % 8);
            bus.m_addr   = $urandom;
            bus.ls_ready = ($urandom % 4) != 0;
            bus.g_ready  = ($urandom % 4) != 0;
            bus.ls_done  = m_lsb && (($urandom % 3) == 0);
            bus.g_done   = m_gb  && (($urandom % 4) == 0);
            drain_req    = ($urandom % 12) == 0;
            nRST         = ($urandom % 500) != 0;
            cyc();
        end
        bus.m_valid = 0; bus.ls_done = 0; bus.g_done = 0; nRST = 1'b1;
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matrix_issue_sched.md
Name: matrix_issue_sched

Overview:
- Single-entry issue scheduler for matrix instructions (ld.m, st.m, gemm), placed between decode/control and the two matrix execution resources: the matrix load/store unit (MLSU) and the GEMM systolic unit.
- Holds one decoded matrix instruction and checks a matrix-register scoreboard for RAW/WAR/WAW hazards.
- Issues to the target unit over a valid/ready handshake and retires on the unit's done pulse.
- Also provides a drain handshake used by halt.

Parameters:
- NUM_MREGS, 16, number of architectural matrix registers.
- MREG_W, 4, matrix register index width (clog2 NUM_MREGS).
- ADDR_W, 32, memory base-address width (word_t).
- STALL_CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- m_valid  in  1  decoded matrix instruction valid
- m_ready  out  1  scheduler can accept an instruction this cycle
- m_op  in  2  instruction type: 0=LD, 1=ST, 2=GEMM; 3 is reserved
- m_rd  in  MREG_W  destination register (LD, GEMM)
- m_rs1, m_rs2, m_rs3  in  MREG_W each  sources: ST data reg = m_rs1; GEMM uses all three (A, B, C)
- m_addr  in  ADDR_W  base address (LD, ST)
- ls_valid  out  1  MLSU request valid
- ls_ready  in  1  MLSU accepts the request
- ls_store  out  1  1=st.m, 0=ld.m
- ls_mreg  out  MREG_W  LD destination or ST source
- ls_addr  out  ADDR_W  base address
- ls_done  in  1  one-cycle pulse: MLSU operation finished
- g_valid  out  1  GEMM request valid
- g_ready  in  1  GEMM unit accepts the request
- g_rs1, g_rs2, g_rs3, g_rd  out  MREG_W each  GEMM operands
- g_done  in  1  one-cycle pulse: GEMM finished and written back
- drain_req  in  1  level; halt requested
- drained  out  1  entry empty and no operation in flight
- err  out  1  sticky: reserved op accepted, or a done pulse arrived with that unit idle
- stall_cnt  out  STALL_CNT_W  saturating count of cycles the entry was valid but blocked by a hazard

Behaviour:
- Reset values: entry invalid, ls_inflight=0, g_inflight=0, all scoreboard records cleared, err=0, stall_cnt=0. After reset: ls_valid=0, g_valid=0, m_ready=1, drained=1.
- Reset asserted mid-operation discards everything. Any later done pulse for the discarded operation sets err.
- Accept rule:
  - m_ready = !drain_req && (!ent_valid || issue_fire).
  - Acceptance when m_valid && m_ready. The entry latches op, rd, rs1–rs3 and addr.
  - A reserved op (3) is accepted and dropped (entry stays invalid) and sets err.
- Scoreboard:
  - wbusy[i] is set if register i is the in-flight LD destination or the in-flight GEMM rd.
  - rbusy[i] is set if register i is the in-flight ST source or any in-flight GEMM source.
  - Computed from the registered in-flight records; it does not include the same cycle's done.
- Hazard for the held entry:
  - LD: wbusy[rd] || rbusy[rd].
  - ST: wbusy[rs1].
  - GEMM: wbusy of any of rs1–rs3, or wbusy[rd] || rbusy[rd].
- Issue:
  - ls_valid = ent_valid && op∈{LD,ST} && !hazard && !ls_inflight. g_valid is analogous for GEMM with g_inflight.
  - Outputs are driven directly from the entry and stay stable while valid is held.
  - issue_fire = valid && ready. On fire: set that unit's in-flight flag, record its registers, clear the entry (unless a new accept occurs the same cycle).
- Retire: a done pulse clears that unit's in-flight flag and records. Done for an idle unit is ignored and sets err.
- Same-cycle events:
  - Done and accept: allowed.
  - Done of one unit and issue to the other: allowed.
  - A unit cannot retire and re-issue in the same cycle; its next issue comes at the earliest in the following cycle.
- Latency: accept at cycle N, earliest ls_valid/g_valid at N+1. Back-to-back operations to different units issue on consecutive cycles.
- stall_cnt increments each cycle ent_valid && hazard, and saturates at all-ones.
- Drain: while drain_req is high, no accepts. drained = !ent_valid && !ls_inflight && !g_inflight, evaluated combinationally from registered state.

Decomposition:
- types_pkg additions: mop_t enum (MOP_LD, MOP_ST, MOP_GEMM, MOP_RSVD), mreg_t (logic [MREG_W-1:0]), and matrix_instr_t struct (op, rd, rs1, rs2, rs3, addr).
- Sub-module mreg_scoreboard: takes the in-flight records and produces wbusy/rbusy vectors plus the hazard bit for the held instruction. It is purely combinational; the top level keeps the entry, in-flight records and counters.

Test Plan:
- LD m2 @0x100 accepted at cycle 1, ls_ready=1 -> ls_valid at cycle 2 with ls_store=0, ls_mreg=2, ls_addr=0x100; m_ready=1 at cycle 2.
- RAW: LD m1 in flight, then GEMM rd=m4, rs=m1,m2,m3 -> g_valid=0 and stall_cnt increments each cycle until ls_done; g_valid is asserted the cycle after ls_done.
- WAR: GEMM reading m5 in flight, then LD m5 -> ls_valid stays 0 until g_done. With drain_req=1 and then done, drained rises only once both units are idle.
- Overlap: GEMM m7 = f(m1, m2, m3) issued, then ST m6 -> ST issues while GEMM is in flight. g_done and ls_done in the same cycle -> both cleared, drained=1.
- Error: g_done pulse with no GEMM in flight -> err=1 and remains 1. m_op=3 accepted -> err=1, no issue.
- Reset: nRST pulsed low while LD is in flight -> all outputs return to reset values immediately; a later ls_done sets err.
